uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the serial link: recovers 8N1 frames (start bit, 8 data bits LSB first, one stop bit) from the asynchronous serial line and presents each received byte with a one-cycle valid pulse. Sits at the line input of the design, feeding bytes to the sorting FSM and pairing with the link's transmitter at the same `CLKS_PER_BIT` setting. It synchronizes the line, samples each bit at mid-bit, and flags framing errors.

## Interface
- `CLKS_PER_BIT`, 57: clock cycles per bit period. Legal range is 4..255.
- `i_Clock` input, 1 bit: system clock. All logic runs on its rising edge.
- `i_Rst_n` input, 1 bit: reset. One clock; reset is asynchronous and active-low.
- `i_Rx_Serial` input, 1 bit: serial line. Asynchronous to `i_Clock`; idles high.
- `o_Rx_DV` output, 1 bit: one-cycle pulse when a good frame completes and `o_Rx_Byte` updates.
- `o_Rx_Byte` output, 8 bits: last good byte. Holds its value until the next good frame.
- `o_Rx_Frame_Err` output, 1 bit: one-cycle pulse when a frame's stop bit samples low.
- `o_Rx_Active` output, 1 bit: high while a frame is being received.

## Operation
- Synchronizer:
  - `i_Rx_Serial` passes through two flops. Both reset to 1.
  - All decisions use the second flop, called `rx_s`.
- Counters:
  - Bit-period counter is 8 bits.
  - Bit index is 3 bits.
  - Shift/data register is 8 bits.
  - H = (CLKS_PER_BIT-1)/2, integer divide (mid-bit offset).
- States: IDLE, START, DATA, STOP, CLEANUP.
  - IDLE: counter=0, index=0. If `rx_s`=0, go to START. Otherwise stay.
  - START: counter increments each cycle. When counter==H:
    - `rx_s`=0: counter←0, go to DATA.
    - `rx_s`=1: glitch/false start, go to IDLE. No output pulse.
  - DATA: counter increments. When counter==CLKS_PER_BIT-1:
    - data[index]←`rx_s`, counter←0.
    - If index<7: index+1, stay in DATA. If index==7: index←0, go to STOP.
  - STOP: counter increments. When counter==CLKS_PER_BIT-1, counter←0 and:
    - `rx_s`=1: `o_Rx_Byte`←data, pulse `o_Rx_DV`.
    - `rx_s`=0: pulse `o_Rx_Frame_Err`. `o_Rx_Byte` is unchanged.
    - Either way, go to CLEANUP.
  - CLEANUP: stay until `rx_s`=1, then go to IDLE. A break (line held low) therefore yields exactly one frame error, not repeated frames.
  - Undefined state encodings go to IDLE.
- `o_Rx_Active` = 1 in START, DATA and STOP; 0 in IDLE and CLEANUP.
- `o_Rx_DV` and `o_Rx_Frame_Err` are mutually exclusive. Each is high for exactly one cycle.

## Timing
- Reset values:
  - `o_Rx_DV`=0, `o_Rx_Frame_Err`=0, `o_Rx_Active`=0, `o_Rx_Byte`=8'h00.
  - State=IDLE. Counters and data register are 0. Synchronizer flops are 1.
- Reset mid-frame: everything clears immediately (asynchronous). No DV or error pulse for the partial frame. Reception resumes on the next falling edge after reset release.
- Let edge k be the first rising edge at which the first sync flop captures 0:
  - `rx_s`=0 after edge k+1.
  - START is entered at edge k+2.
  - Start bit is validated at edge k+3+H.
  - Data bit i is sampled at edge k+3+H+(i+1)·CLKS_PER_BIT.
  - Stop bit is sampled at edge k+3+H+9·CLKS_PER_BIT.
  - `o_Rx_DV` or `o_Rx_Frame_Err` is high for the cycle following that edge.
- `o_Rx_Active` rises after edge k+2. It falls on the same edge that raises DV or the error pulse.
- Back-to-back frames: a new start bit immediately following the stop bit is accepted. CLEANUP exits in one cycle when `rx_s`=1.
- Tolerance: sampling at mid-bit gives ±H cycles of accumulated skew margin over a frame.

## Test plan
- CLKS_PER_BIT=8, send 0xA5 with a good stop bit → one `o_Rx_DV` pulse; `o_Rx_Byte`=8'hA5; `o_Rx_Active` high from k+3 through the DV edge; `o_Rx_Frame_Err` never asserts.
- Two back-to-back frames 0x00 then 0xFF, no idle gap → two DV pulses spaced 10·8=80 cycles apart; `o_Rx_Byte` reads 8'h00, then 8'hFF.
- Send 0x3C with the stop bit driven low, then return high → one `o_Rx_Frame_Err` pulse, no DV; `o_Rx_Byte` keeps its previous value; next good frame 0x81 → DV with 8'h81.
- Low glitch of 2 cycles on an idle line (CLKS_PER_BIT=8, H=3) → state returns to IDLE; no DV or error pulse; `o_Rx_Active` pulses high only during START.
- Line held low for 30 bit periods (break), then released → exactly one `o_Rx_Frame_Err`; block stays in CLEANUP until the line goes high; a following frame 0x5A is received correctly.
- Assert `i_Rst_n`=0 during data bit 4 of frame 0xC3 → all outputs go to their reset values immediately; no pulse for that frame; after release, frame 0x11 → DV with 8'h11.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling and stop-bit framing check.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line idle, waiting for a low level on the synchronized line
// START   | timing to the middle of the start bit to confirm it is real
// DATA    | sampling the 8 data bits, LSB first, one per bit period
// STOP    | sampling the stop bit; good frame -> DV, low -> framing error
// CLEANUP | waiting for the line to return high (absorbs a held break)
module uart_rx #(
    parameter int CLKS_PER_BIT = 57
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [7:0] HALF_CNT = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] data_q, data_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       ferr_q, ferr_d;
    logic       sync1_q, sync2_q;
    logic       rx_s;

    assign rx_s = sync2_q;

    // Two-flop synchronizer for the asynchronous line; resets to the idle level.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_Rx_Serial;
            sync2_q <= sync1_q;
        end
    end

    // State, counters, shift register and registered output pulses.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            data_q  <= 8'd0;
            byte_q  <= 8'd0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, bit timing and sampling decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                idx_d = 3'd0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_CNT) begin
                    cnt_d   = 8'd0;
                    // A line back high at mid-start is a glitch, not a frame.
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d         = 8'd0;
                    data_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = 8'd0;
                    state_d = CLEANUP;
                    if (rx_s) begin
                        byte_d = data_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLEANUP: begin
                if (rx_s) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Frame_Err = ferr_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Active    = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames at CLKS_PER_BIT=8 with table-driven frame checks
// plus hand sequences for glitch, break and mid-frame reset.
module tb_uart_rx;

    localparam int CPB = 8;
    // Cycles from the drive negedge to the negedge where the DV/error pulse is seen:
    // edge k is one posedge after the drive, the pulse follows edge k+3+H+9*CPB.
    localparam int PULSE_LAT = 1 + 3 + 3 + 9 * CPB;
    // Active is high after edges k+2 .. k+3+H+9*CPB-1.
    localparam int ACTIVE_CYC = 1 + 3 + 9 * CPB;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic       dv;
    logic [7:0] rx_byte;
    logic       ferr;
    logic       active;

    int checks;
    int failures;
    int cyc;
    int dv_total;
    int ferr_total;
    int active_total;
    int last_dv_cyc;
    int last_evt_cyc;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock        (clk),
        .i_Rst_n        (rst_n),
        .i_Rx_Serial    (rx),
        .o_Rx_DV        (dv),
        .o_Rx_Byte      (rx_byte),
        .o_Rx_Frame_Err (ferr),
        .o_Rx_Active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse/activity monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (active) active_total <= active_total + 1;
        if (dv) begin
            dv_total    <= dv_total + 1;
            last_dv_cyc <= cyc;
        end
        if (ferr) ferr_total <= ferr_total + 1;
        if (dv || ferr) begin
            last_evt_cyc <= cyc;
            check("dv_ferr_exclusive", {31'd0, dv & ferr}, 32'd0);
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap_bits;
        int         exp_dv;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[5];
    int   start_cyc;
    int   dv0, ferr0, act0;
    int   prev_dv_cyc;

    task automatic drive_bit(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
        drive_bit(stop, CPB);
    endtask

    task automatic snap();
        dv0   = dv_total;
        ferr0 = ferr_total;
        act0  = active_total;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        dv_total = 0; ferr_total = 0; active_total = 0;
        last_dv_cyc = 0; last_evt_cyc = 0; prev_dv_cyc = 0;

        vecs[0] = '{8'hA5, 1'b1, 2, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 2, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b0, 2, 0, 1, 8'hFF};
        vecs[4] = '{8'h81, 1'b1, 2, 1, 0, 8'h81};

        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dv", {31'd0, dv}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_byte", {24'd0, rx_byte}, 32'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            snap();
            send_frame(vecs[v].data, vecs[v].stop);
            drive_bit(1'b1, vecs[v].gap_bits * CPB);
            check($sformatf("v%0d_dv_count", v), dv_total - dv0, vecs[v].exp_dv);
            check($sformatf("v%0d_ferr_count", v), ferr_total - ferr0, vecs[v].exp_ferr);
            check($sformatf("v%0d_byte", v), {24'd0, rx_byte}, {24'd0, vecs[v].exp_byte});
            check($sformatf("v%0d_active_cycles", v), active_total - act0, ACTIVE_CYC);
            check($sformatf("v%0d_pulse_latency", v), last_evt_cyc - start_cyc, PULSE_LAT);
            if (v == 2) check("b2b_dv_spacing", last_dv_cyc - prev_dv_cyc, 10 * CPB);
            prev_dv_cyc = last_dv_cyc;
        end

        // Two-cycle low glitch: START for H+1 cycles, then back to IDLE silently.
        snap();
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 4 * CPB);
        check("glitch_dv", dv_total - dv0, 0);
        check("glitch_ferr", ferr_total - ferr0, 0);
        check("glitch_active_cycles", active_total - act0, 4);
        check("glitch_byte_held", {24'd0, rx_byte}, 32'h81);

        // Break of 30 bit periods: one framing error, then parked in CLEANUP.
        snap();
        start_cyc = cyc;
        drive_bit(1'b0, 30 * CPB);
        check("break_active_low", {31'd0, active}, 32'd0);
        drive_bit(1'b1, 2 * CPB);
        check("break_ferr_count", ferr_total - ferr0, 1);
        check("break_dv_count", dv_total - dv0, 0);
        check("break_active_cycles", active_total - act0, ACTIVE_CYC);
        check("break_ferr_latency", last_evt_cyc - start_cyc, PULSE_LAT);
        snap();
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        check("after_break_dv", dv_total - dv0, 1);
        check("after_break_byte", {24'd0, rx_byte}, 32'h5A);

        // Reset asserted during data bit 4 of 0xC3.
        snap();
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 4; i++) drive_bit(i < 2 ? 1'b1 : 1'b0, CPB);
        drive_bit(1'b0, 4);
        check("pre_reset_active", {31'd0, active}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_active", {31'd0, active}, 32'd0);
        check("midrst_dv", {31'd0, dv}, 32'd0);
        check("midrst_ferr", {31'd0, ferr}, 32'd0);
        check("midrst_byte", {24'd0, rx_byte}, 32'h00);
        @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("midrst_no_pulse", (dv_total - dv0) + (ferr_total - ferr0), 0);
        snap();
        send_frame(8'h11, 1'b1);
        drive_bit(1'b1, 2 * CPB);
        check("post_reset_dv", dv_total - dv0, 1);
        check("post_reset_byte", {24'd0, rx_byte}, 32'h11);
        check("post_reset_latency", last_evt_cyc - start_cyc, PULSE_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
